// File: rtl/spi_slave_burst_controller.sv
// SPI slave burst controller: decodes WRITE/READ/FAST_READ, sequences address,
// dummy and data phases, and drives the shifter counters and memory-side handshakes.
module spi_slave_burst_controller #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   localparam int RX_WIDTH  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH
) (
   input  logic                  sclk,
   input  logic                  cs,
   output logic [7:0]            rx_counter,
   output logic                  rx_counter_upd,
   input  logic [RX_WIDTH-1:0]   rx_data,
   input  logic                  rx_data_valid,
   output logic [7:0]            tx_counter,
   output logic                  tx_counter_upd,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_data_valid,
   input  logic                  tx_done,
   output logic                  ctrl_rd_wr,
   output logic [ADDR_WIDTH-1:0] ctrl_addr,
   output logic                  ctrl_addr_valid,
   output logic [DATA_WIDTH-1:0] ctrl_data_rx,
   output logic                  ctrl_data_rx_valid,
   input  logic [DATA_WIDTH-1:0] ctrl_data_tx,
   output logic                  ctrl_data_tx_ready,
   input  logic [7:0]            cfg_dummy_cycles,
   input  logic [15:0]           cfg_wrap_words,
   output logic                  err_illegal_cmd
);

   localparam logic [7:0] OP_WRITE     = 8'h02;
   localparam logic [7:0] OP_READ      = 8'h03;
   localparam logic [7:0] OP_FAST_READ = 8'h0B;

   typedef enum logic [2:0] {CMD, ADDR, DUMMY, DATA_RX, DATA_TX, IGNORE} state_t;

   state_t                state, state_nxt;
   logic [7:0]            opcode;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [15:0]           word_idx;
   logic                  tx_done_p1;
   logic                  load_addr, advance, load_tx, err_set;

   assign ctrl_rd_wr   = (opcode == OP_READ) || (opcode == OP_FAST_READ);
   assign ctrl_data_rx = rx_data[DATA_WIDTH-1:0];

   always_comb begin
      state_nxt          = state;
      rx_counter_upd     = 1'b0;
      ctrl_data_rx_valid = 1'b0;
      load_addr          = 1'b0;
      advance            = 1'b0;
      load_tx            = 1'b0;
      err_set            = 1'b0;
      if (!cs) begin
         case (state)
            CMD: if (rx_data_valid) begin
               if (rx_data[7:0] == OP_WRITE || rx_data[7:0] == OP_READ ||
                   rx_data[7:0] == OP_FAST_READ) begin
                  state_nxt      = ADDR;
                  rx_counter_upd = 1'b1;
               end else begin
                  state_nxt = IGNORE;
                  err_set   = 1'b1;
               end
            end
            ADDR: if (rx_data_valid) begin
               load_addr = 1'b1;
               if (opcode == OP_WRITE) begin
                  state_nxt      = DATA_RX;
                  rx_counter_upd = 1'b1;
               end else if (opcode == OP_FAST_READ && cfg_dummy_cycles != 8'd0) begin
                  state_nxt      = DUMMY;
                  rx_counter_upd = 1'b1;
               end else begin
                  state_nxt = DATA_TX;
                  load_tx   = 1'b1;
               end
            end
            DUMMY: if (rx_data_valid) begin
               state_nxt = DATA_TX;
               load_tx   = 1'b1;
            end
            DATA_RX: if (rx_data_valid) begin
               ctrl_data_rx_valid = 1'b1;
               advance            = 1'b1;
               rx_counter_upd     = 1'b1;
            end
            DATA_TX: if (tx_done_p1) begin
               advance = 1'b1;
               load_tx = 1'b1;
            end
            default: state_nxt = state;
         endcase
      end
   end

   // rx_counter always describes the field the shifter collects next
   always_comb begin
      case (state_nxt)
         CMD:     rx_counter = 8'd7;
         ADDR:    rx_counter = 8'(ADDR_WIDTH - 1);
         DUMMY:   rx_counter = cfg_dummy_cycles - 8'd1;
         DATA_RX: rx_counter = 8'(DATA_WIDTH - 1);
         default: rx_counter = 8'd0;
      endcase
   end

   always_ff @(posedge sclk or posedge cs) begin
      if (cs) state <= CMD;
      else    state <= state_nxt;
   end

   always_ff @(posedge sclk or posedge cs) begin
      if (cs) begin
         opcode             <= 8'd0;
         base_addr          <= '0;
         ctrl_addr          <= '0;
         word_idx           <= 16'd0;
         ctrl_addr_valid    <= 1'b0;
         tx_done_p1         <= 1'b0;
         tx_data            <= '0;
         tx_data_valid      <= 1'b0;
         tx_counter         <= 8'd0;
         tx_counter_upd     <= 1'b0;
         ctrl_data_tx_ready <= 1'b0;
         err_illegal_cmd    <= 1'b0;
      end else begin
         tx_done_p1         <= tx_done;
         ctrl_addr_valid    <= load_addr | advance;
         tx_data_valid      <= load_tx;
         tx_counter_upd     <= load_tx;
         ctrl_data_tx_ready <= load_tx;
         if (state == CMD && rx_data_valid) opcode <= rx_data[7:0];
         if (err_set) err_illegal_cmd <= 1'b1;
         if (load_addr) begin
            base_addr <= rx_data[ADDR_WIDTH-1:0];
            ctrl_addr <= rx_data[ADDR_WIDTH-1:0];
            word_idx  <= 16'd0;
         end else if (advance) begin
            // wrap length is read live so a mid-burst change applies at the next word
            if (cfg_wrap_words != 16'd0 && word_idx + 16'd1 == cfg_wrap_words) begin
               ctrl_addr <= base_addr;
               word_idx  <= 16'd0;
            end else begin
               ctrl_addr <= ctrl_addr + ADDR_WIDTH'(DATA_WIDTH / 8);
               word_idx  <= word_idx + 16'd1;
            end
         end
         if (load_tx) begin
            tx_data    <= ctrl_data_tx;
            tx_counter <= 8'(DATA_WIDTH - 1);
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_burst_controller.sv
// Directed bench for spi_slave_burst_controller: cycle table plus wrap and async-abort sequences.
module tb_spi_slave_burst_controller;

   logic        sclk = 1'b0;
   logic        cs = 1'b1;
   logic [7:0]  rx_counter;
   logic        rx_counter_upd;
   logic [31:0] rx_data = 32'd0;
   logic        rx_data_valid = 1'b0;
   logic [7:0]  tx_counter;
   logic        tx_counter_upd;
   logic [31:0] tx_data;
   logic        tx_data_valid;
   logic        tx_done = 1'b0;
   logic        ctrl_rd_wr;
   logic [31:0] ctrl_addr;
   logic        ctrl_addr_valid;
   logic [31:0] ctrl_data_rx;
   logic        ctrl_data_rx_valid;
   logic [31:0] ctrl_data_tx = 32'd0;
   logic        ctrl_data_tx_ready;
   logic [7:0]  cfg_dummy_cycles = 8'd0;
   logic [15:0] cfg_wrap_words = 16'd0;
   logic        err_illegal_cmd;

   int applied = 0;
   int miscompares = 0;

   spi_slave_burst_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .sclk(sclk), .cs(cs),
      .rx_counter(rx_counter), .rx_counter_upd(rx_counter_upd),
      .rx_data(rx_data), .rx_data_valid(rx_data_valid),
      .tx_counter(tx_counter), .tx_counter_upd(tx_counter_upd),
      .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_done(tx_done),
      .ctrl_rd_wr(ctrl_rd_wr), .ctrl_addr(ctrl_addr), .ctrl_addr_valid(ctrl_addr_valid),
      .ctrl_data_rx(ctrl_data_rx), .ctrl_data_rx_valid(ctrl_data_rx_valid),
      .ctrl_data_tx(ctrl_data_tx), .ctrl_data_tx_ready(ctrl_data_tx_ready),
      .cfg_dummy_cycles(cfg_dummy_cycles), .cfg_wrap_words(cfg_wrap_words),
      .err_illegal_cmd(err_illegal_cmd)
   );

   always #5 sclk = ~sclk;

   typedef struct {
      logic        cs, rv;
      logic [31:0] rd;
      logic        td;
      logic [7:0]  dum;
      logic [31:0] dtx;
      logic [7:0]  rxc;
      logic        rxu, drv;
      logic [31:0] addr;
      logic        av, txv;
      logic [31:0] txd;
      logic        err, rw;
   } vec_t;

   function automatic vec_t mk(logic cs_i, logic rv, logic [31:0] rd, logic td, logic [7:0] dum,
                               logic [31:0] dtx, logic [7:0] rxc, logic rxu, logic drv,
                               logic [31:0] addr, logic av, logic txv, logic [31:0] txd,
                               logic err, logic rw);
      vec_t v;
      v.cs = cs_i; v.rv = rv; v.rd = rd; v.td = td; v.dum = dum; v.dtx = dtx;
      v.rxc = rxc; v.rxu = rxu; v.drv = drv; v.addr = addr; v.av = av; v.txv = txv;
      v.txd = txd; v.err = err; v.rw = rw;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic c, input logic rv, input logic [31:0] rd, input logic td);
      @(negedge sclk);
      cs = c; rx_data_valid = rv; rx_data = rd; tx_done = td;
      @(posedge sclk);
      #1;
   endtask

   localparam int NV = 27;
   vec_t tbl [NV];
   logic [31:0] wrap_exp [6];

   initial begin
      //             cs    rv    rd            td    dum    dtx           rxc    rxu   drv   addr          av    txv   txd           err   rw
      // WRITE 0x100, three words
      tbl[0]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 8'd0, 32'h0,        8'd7,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
      tbl[1]  = mk(1'b0, 1'b1, 32'h02,       1'b0, 8'd0, 32'h0,        8'd31, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
      tbl[2]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 8'd0, 32'h0,        8'd31, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
      tbl[3]  = mk(1'b0, 1'b1, 32'h100,      1'b0, 8'd0, 32'h0,        8'd31, 1'b1, 1'b0, 32'h100,      1'b1, 1'b0, 32'h0,        1'b0, 1'b0);
      tbl[4]  = mk(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 8'd0, 32'h0,        8'd31, 1'b1, 1'b1, 32'h104,      1'b1, 1'b0, 32'h0,        1'b0, 1'b0);
      tbl[5]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 8'd0, 32'h0,        8'd31, 1'b0, 1'b0, 32'h104,      1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
      tbl[6]  = mk(1'b0, 1'b1, 32'h11111111, 1'b0, 8'd0, 32'h0,        8'd31, 1'b1, 1'b1, 32'h108,      1'b1, 1'b0, 32'h0,        1'b0, 1'b0);
      tbl[7]  = mk(1'b0, 1'b1, 32'h22222222, 1'b0, 8'd0, 32'h0,        8'd31, 1'b1, 1'b1, 32'h10C,      1'b1, 1'b0, 32'h0,        1'b0, 1'b0);
      tbl[8]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 8'd0, 32'h0,        8'd7,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
      // FAST_READ 0x40, 8 dummy cycles, three words, then cs abort
      tbl[9]  = mk(1'b0, 1'b1, 32'h0B,       1'b0, 8'd8, 32'h0,        8'd31, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1);
      tbl[10] = mk(1'b0, 1'b1, 32'h40,       1'b0, 8'd8, 32'h0,        8'd7,  1'b1, 1'b0, 32'h40,       1'b1, 1'b0, 32'h0,        1'b0, 1'b1);
      tbl[11] = mk(1'b0, 1'b0, 32'h0,        1'b0, 8'd8, 32'h0,        8'd7,  1'b0, 1'b0, 32'h40,       1'b0, 1'b0, 32'h0,        1'b0, 1'b1);
      tbl[12] = mk(1'b0, 1'b1, 32'h0,        1'b0, 8'd8, 32'hA0A0A0A0, 8'd0,  1'b0, 1'b0, 32'h40,       1'b0, 1'b1, 32'hA0A0A0A0, 1'b0, 1'b1);
      tbl[13] = mk(1'b0, 1'b0, 32'h0,        1'b0, 8'd8, 32'hA1A1A1A1, 8'd0,  1'b0, 1'b0, 32'h40,       1'b0, 1'b0, 32'hA0A0A0A0, 1'b0, 1'b1);
      tbl[14] = mk(1'b0, 1'b0, 32'h0,        1'b1, 8'd8, 32'hA1A1A1A1, 8'd0,  1'b0, 1'b0, 32'h40,       1'b0, 1'b0, 32'hA0A0A0A0, 1'b0, 1'b1);
      tbl[15] = mk(1'b0, 1'b0, 32'h0,        1'b0, 8'd8, 32'hA1A1A1A1, 8'd0,  1'b0, 1'b0, 32'h44,       1'b1, 1'b1, 32'hA1A1A1A1, 1'b0, 1'b1);
      tbl[16] = mk(1'b0, 1'b0, 32'h0,        1'b1, 8'd8, 32'hA2A2A2A2, 8'd0,  1'b0, 1'b0, 32'h44,       1'b0, 1'b0, 32'hA1A1A1A1, 1'b0, 1'b1);
      tbl[17] = mk(1'b0, 1'b0, 32'h0,        1'b0, 8'd8, 32'hA2A2A2A2, 8'd0,  1'b0, 1'b0, 32'h48,       1'b1, 1'b1, 32'hA2A2A2A2, 1'b0, 1'b1);
      tbl[18] = mk(1'b1, 1'b0, 32'h0,        1'b1, 8'd8, 32'hA3A3A3A3, 8'd7,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
      // illegal opcode, traffic ignored, flag cleared by cs
      tbl[19] = mk(1'b0, 1'b1, 32'hFF,       1'b0, 8'd0, 32'h0,        8'd0,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0);
      tbl[20] = mk(1'b0, 1'b1, 32'h100,      1'b0, 8'd0, 32'h0,        8'd0,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0);
      tbl[21] = mk(1'b0, 1'b0, 32'h0,        1'b1, 8'd0, 32'h0,        8'd0,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0);
      tbl[22] = mk(1'b0, 1'b1, 32'h55,       1'b0, 8'd0, 32'h0,        8'd0,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0);
      tbl[23] = mk(1'b1, 1'b0, 32'h0,        1'b0, 8'd0, 32'h0,        8'd7,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
      // FAST_READ with no dummy cycles goes straight to data
      tbl[24] = mk(1'b0, 1'b1, 32'h0B,       1'b0, 8'd0, 32'h0,        8'd31, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1);
      tbl[25] = mk(1'b0, 1'b1, 32'h80,       1'b0, 8'd0, 32'hB0B0B0B0, 8'd0,  1'b0, 1'b0, 32'h80,       1'b1, 1'b1, 32'hB0B0B0B0, 1'b0, 1'b1);
      tbl[26] = mk(1'b1, 1'b0, 32'h0,        1'b0, 8'd0, 32'h0,        8'd7,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0);

      wrap_exp[0] = 32'h200; wrap_exp[1] = 32'h204; wrap_exp[2] = 32'h208;
      wrap_exp[3] = 32'h20C; wrap_exp[4] = 32'h200; wrap_exp[5] = 32'h204;

      for (int i = 0; i < NV; i++) begin
         logic [7:0] c_rxc;
         logic       c_rxu, c_drv;
         @(negedge sclk);
         cs = tbl[i].cs; rx_data_valid = tbl[i].rv; rx_data = tbl[i].rd;
         tx_done = tbl[i].td; cfg_dummy_cycles = tbl[i].dum; ctrl_data_tx = tbl[i].dtx;
         #1;
         c_rxc = rx_counter; c_rxu = rx_counter_upd; c_drv = ctrl_data_rx_valid;
         @(posedge sclk);
         #1;
         applied++;
         if (c_rxc !== tbl[i].rxc || c_rxu !== tbl[i].rxu || c_drv !== tbl[i].drv ||
             ctrl_addr !== tbl[i].addr || ctrl_addr_valid !== tbl[i].av ||
             tx_data_valid !== tbl[i].txv || tx_counter_upd !== tbl[i].txv ||
             ctrl_data_tx_ready !== tbl[i].txv || tx_data !== tbl[i].txd ||
             err_illegal_cmd !== tbl[i].err || ctrl_rd_wr !== tbl[i].rw) begin
            miscompares++;
            $display("FAIL vec%0d: got rxc=%0d upd=%b drv=%b addr=%0h av=%b txv=%b/%b/%b txd=%0h err=%b rw=%b, expected rxc=%0d upd=%b drv=%b addr=%0h av=%b txv=%b txd=%0h err=%b rw=%b",
                     i, c_rxc, c_rxu, c_drv, ctrl_addr, ctrl_addr_valid, tx_data_valid,
                     tx_counter_upd, ctrl_data_tx_ready, tx_data, err_illegal_cmd, ctrl_rd_wr,
                     tbl[i].rxc, tbl[i].rxu, tbl[i].drv, tbl[i].addr, tbl[i].av, tbl[i].txv,
                     tbl[i].txd, tbl[i].err, tbl[i].rw);
         end
      end

      // write data passes straight through to the memory side
      @(negedge sclk);
      rx_data = 32'h12345678;
      #1;
      check("data_rx_passthru", 64'(ctrl_data_rx), 64'h12345678);

      // READ with a 4-word wrap over six words
      cfg_wrap_words = 16'd4;
      cfg_dummy_cycles = 8'd0;
      ctrl_data_tx = 32'hC0C0C0C0;
      cyc(1'b0, 1'b1, 32'h03, 1'b0);
      check("read_rd_wr", 64'(ctrl_rd_wr), 64'd1);
      cyc(1'b0, 1'b1, 32'h200, 1'b0);
      check("wrap_addr0", 64'(ctrl_addr), 64'(wrap_exp[0]));
      check("wrap_txv0", 64'(tx_data_valid), 64'd1);
      check("tx_counter_load", 64'(tx_counter), 64'd31);
      for (int k = 1; k < 6; k++) begin
         cyc(1'b0, 1'b0, 32'h0, 1'b1);
         cyc(1'b0, 1'b0, 32'h0, 1'b0);
         check($sformatf("wrap_addr%0d", k), 64'(ctrl_addr), 64'(wrap_exp[k]));
         check($sformatf("wrap_av%0d", k), 64'(ctrl_addr_valid), 64'd1);
      end

      // cs rises while load pulses are high: outputs clear without a clock edge
      #1;
      cs = 1'b1;
      #1;
      check("abort_txv", 64'(tx_data_valid), 64'd0);
      check("abort_rdy", 64'(ctrl_data_tx_ready), 64'd0);
      check("abort_av", 64'(ctrl_addr_valid), 64'd0);
      check("abort_addr", 64'(ctrl_addr), 64'd0);
      check("abort_txd", 64'(tx_data), 64'd0);
      check("abort_txcnt", 64'(tx_counter), 64'd0);
      check("abort_rxcnt", 64'(rx_counter), 64'd7);

      // next transaction starts from CMD
      cfg_wrap_words = 16'd0;
      cyc(1'b0, 1'b1, 32'h02, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      check("restart_addr_phase", 64'(rx_counter), 64'd31);
      check("restart_rd_wr", 64'(ctrl_rd_wr), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
